// File: rtl/ads_bus_pkg.sv
// Shared definitions for the serial bus master/slave port pair.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default address and data widths
//   MODE_READ / MODE_WRITE          : value of the mode line for each direction
//   master_state_t                  : master port state encoding
//   max_int                         : helper for sizing shared counters
package ads_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_REQ   = 3'd1,
        M_ADDR  = 3'd2,
        M_GAP   = 3'd3,
        M_WDATA = 3'd4,
        M_WEND  = 3'd5,
        M_RWAIT = 3'd6,
        M_DONE  = 3'd7
    } master_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/master_port.sv
// Master-side serial bus port.
// Takes one parallel read/write request from a device, requests the bus,
// shifts address (and write data) LSB-first onto mwdata, or collects read
// data one bit per svalid pulse, then reports completion on dack/derr.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   dvalid/dwen/daddr/dwdata   device request (sampled only while idle)
//   drdata/dready/dack/derr    device response
//   mbreq/mbgrant       arbiter handshake
//   mwdata/mmode/mvalid serial output towards the slave
//   srdata/svalid/sready/ssplit  serial input and status from the slave
//
// Every output is a register loaded from the next-state value, so outputs
// line up with the state the port is in during that cycle.
module master_port
    import ads_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dvalid,
    input  logic                  dwen,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  dready,
    output logic                  dack,
    output logic                  derr,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  srdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);

    localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH)) + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    master_state_t state_reg, state_next;

    logic [CNT_W-1:0]      cnt_reg,    cnt_next;
    logic [TO_W-1:0]       tcnt_reg,   tcnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg,   addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg,  wdata_next;
    logic [DATA_WIDTH-1:0] rdata_reg,  rdata_next;
    logic                  mode_reg,   mode_next;
    logic                  err_reg,    err_next;
    logic                  mbreq_reg,  mbreq_next;

    logic [DATA_WIDTH-1:0] drdata_reg, drdata_next;
    logic                  dready_reg, dready_next;
    logic                  dack_reg,   dack_next;
    logic                  derr_reg,   derr_next;
    logic                  mwdata_reg, mwdata_next;
    logic                  mvalid_reg, mvalid_next;

    // Next-state, datapath and counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tcnt_next  = tcnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        mode_next  = mode_reg;
        err_next   = err_reg;
        mbreq_next = mbreq_reg;

        case (state_reg)
            M_IDLE: begin
                if (dvalid) begin
                    addr_next  = daddr;
                    wdata_next = dwdata;
                    mode_next  = dwen;
                    rdata_next = '0;
                    err_next   = 1'b0;
                    mbreq_next = 1'b1;
                    state_next = M_REQ;
                end
            end
            M_REQ: begin
                if (mbgrant && sready) begin
                    cnt_next   = '0;
                    state_next = M_ADDR;
                end
            end
            M_ADDR: begin
                if (cnt_reg == ADDR_LAST) begin
                    cnt_next   = '0;
                    tcnt_next  = '0;
                    state_next = (mode_reg == MODE_WRITE) ? M_GAP : M_RWAIT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            M_GAP: begin
                state_next = M_WDATA;
            end
            M_WDATA: begin
                if (cnt_reg == DATA_LAST) begin
                    cnt_next   = '0;
                    state_next = M_WEND;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            M_WEND: begin
                // cnt is 0 in the first WEND cycle: the slave is still
                // committing the write, so its sready is not trusted yet.
                if ((cnt_reg != '0) && sready) begin
                    state_next = M_DONE;
                end else begin
                    cnt_next = CNT_W'(1);
                end
            end
            M_RWAIT: begin
                if (ssplit) begin
                    mbreq_next = 1'b0;
                end
                // A data bit always beats an expiring timeout.
                if (svalid) begin
                    rdata_next = rdata_reg | (DATA_WIDTH'(srdata) << cnt_reg);
                    tcnt_next  = '0;
                    if (cnt_reg == DATA_LAST) begin
                        state_next = M_DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else if (tcnt_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = M_DONE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            M_DONE: begin
                state_next = M_IDLE;
            end
            default: begin
                state_next = M_IDLE;
            end
        endcase

        if (state_next == M_DONE) begin
            mbreq_next = 1'b0;
        end
    end

    // Output values for the cycle the port is about to enter.
    always_comb begin
        mvalid_next = (state_next == M_ADDR) || (state_next == M_WDATA);
        mwdata_next = 1'b0;
        if (state_next == M_ADDR) begin
            mwdata_next = |(addr_next & (ADDR_WIDTH'(1) << cnt_next));
        end else if (state_next == M_WDATA) begin
            mwdata_next = |(wdata_next & (DATA_WIDTH'(1) << cnt_next));
        end
        dready_next = (state_next == M_IDLE);
        dack_next   = (state_next == M_DONE);
        derr_next   = (state_next == M_DONE) && err_next;
        drdata_next = drdata_reg;
        // A timed-out read leaves the last good read data in place.
        if ((state_next == M_DONE) && (mode_reg == MODE_READ) && !err_next) begin
            drdata_next = rdata_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= M_IDLE;
            cnt_reg    <= '0;
            tcnt_reg   <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            mode_reg   <= MODE_READ;
            err_reg    <= 1'b0;
            mbreq_reg  <= 1'b0;
            drdata_reg <= '0;
            dready_reg <= 1'b1;
            dack_reg   <= 1'b0;
            derr_reg   <= 1'b0;
            mwdata_reg <= 1'b0;
            mvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tcnt_reg   <= tcnt_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rdata_reg  <= rdata_next;
            mode_reg   <= mode_next;
            err_reg    <= err_next;
            mbreq_reg  <= mbreq_next;
            drdata_reg <= drdata_next;
            dready_reg <= dready_next;
            dack_reg   <= dack_next;
            derr_reg   <= derr_next;
            mwdata_reg <= mwdata_next;
            mvalid_reg <= mvalid_next;
        end
    end

    assign drdata = drdata_reg;
    assign dready = dready_reg;
    assign dack   = dack_reg;
    assign derr   = derr_reg;
    assign mbreq  = mbreq_reg;
    assign mwdata = mwdata_reg;
    assign mmode  = mode_reg;
    assign mvalid = mvalid_reg;

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: expected dack responses are queued at
// issue time and checked by an independent monitor; a small slave model
// deserialises the serial stream into a memory.
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          dvalid;
    logic          dwen;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          dready;
    logic          dack;
    logic          derr;
    logic          mbreq;
    logic          mbgrant;
    logic          mwdata;
    logic          mmode;
    logic          mvalid;
    logic          srdata;
    logic          svalid;
    logic          sready;
    logic          ssplit;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .dvalid(dvalid), .dwen(dwen), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dready(dready), .dack(dack), .derr(derr),
        .mbreq(mbreq), .mbgrant(mbgrant),
        .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
        .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic          err;
        logic [DW-1:0] rd;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   txn = 0;

    always @(negedge clk) begin
        if (dack) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_dack: got dack=1 at cycle %0d, required no pending transfer", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("dack_derr", 32'(derr), 32'(mon_e.err));
                chk("dack_drdata", 32'(drdata), 32'(mon_e.rd));
                txn++;
                $display("txn %0d: cycle %0d derr=%0b drdata=%02h (expected derr=%0b drdata=%02h)",
                         txn, cyc, derr, drdata, mon_e.err, mon_e.rd);
            end
        end
    end

    // ---------------- slave capture model ----------------
    int            mbits = 0;
    logic [19:0]   shreg = '0;
    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] cap_addr = '0;
    logic          cap_mode = 1'b0;
    int            addr_first_cyc = 0;
    int            addr_last_cyc  = 0;
    int            data_first_cyc = 0;

    always @(negedge clk) begin
        if (rst || dready) begin
            mbits <= 0;
        end else if (mvalid) begin
            if (mbits == 0) begin
                addr_first_cyc <= cyc;
                cap_mode       <= mmode;
            end
            if (mbits == 11) begin
                addr_last_cyc <= cyc;
                cap_addr      <= {mwdata, shreg[19:9]};
            end
            if (mbits == 12) data_first_cyc <= cyc;
            if (mbits == 19) mem[shreg[12:1]] <= {mwdata, shreg[19:13]};
            shreg <= {mwdata, shreg[19:1]};
            mbits <= mbits + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    int issue_cyc = 0;

    task automatic issue(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        dvalid = 1'b1; dwen = wen; daddr = a; dwdata = d;
        issue_cyc = cyc;
        @(posedge clk); #1;
        dvalid = 1'b0;
    endtask

    task automatic wait_mbits(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (mbits >= n) return;
        end
        compared++;
        mismatched++;
        $display("FAIL %s: got %0d serial bits, required %0d within 200 cycles", name, mbits, n);
    endtask

    task automatic wait_dack(input string name, output int dcyc, output logic mb);
        dcyc = -1;
        mb   = 1'bx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dack) begin
                dcyc = cyc;
                mb   = mbreq;
                return;
            end
        end
        compared++;
        mismatched++;
        $display("FAIL %s: got no dack, required dack within 200 cycles", name);
    endtask

    // Drive DW data bits; gap=1 inserts an idle cycle between svalid pulses.
    // Returns in the cycle after the last svalid pulse.
    task automatic send_bits(input logic [DW-1:0] v, input bit gap,
                             output int last_sv, output logic mb_or, output logic mb_and);
        mb_or  = 1'b0;
        mb_and = 1'b1;
        for (int i = 0; i < DW; i++) begin
            svalid = 1'b1;
            srdata = v[i];
            last_sv = cyc;
            mb_or  = mb_or | mbreq;
            mb_and = mb_and & mbreq;
            @(posedge clk); #1;
            svalid = 1'b0;
            srdata = 1'b0;
            if (gap && i < DW - 1) begin
                mb_or  = mb_or | mbreq;
                mb_and = mb_and & mbreq;
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before 500000");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int   dcyc, last_sv, a0, gcyc;
        logic mb, mb_or, mb_and, mv_seen;
        logic [DW-1:0] resp;

        rst = 1'b1; dvalid = 1'b0; dwen = 1'b0; daddr = '0; dwdata = '0;
        mbgrant = 1'b1; sready = 1'b1; srdata = 1'b0; svalid = 1'b0; ssplit = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dready", 32'(dready), 32'd1);
        chk("rst_dack",   32'(dack),   32'd0);
        chk("rst_derr",   32'(derr),   32'd0);
        chk("rst_mbreq",  32'(mbreq),  32'd0);
        chk("rst_mvalid", 32'(mvalid), 32'd0);
        chk("rst_mmode",  32'(mmode),  32'd0);
        chk("rst_drdata", 32'(drdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write 0xA5 to 0x3C4, grant already high
        sb.push_back('{err: 1'b0, rd: 8'h00});
        issue(1'b1, 12'h3C4, 8'hA5);
        wait_dack("wr_dack", dcyc, mb);
        chk("wr_latency", 32'(dcyc - issue_cyc), 32'd25);
        chk("wr_addr_start", 32'(addr_first_cyc - issue_cyc), 32'd2);
        chk("wr_gap", 32'(data_first_cyc - addr_first_cyc), 32'd13);
        chk("wr_cap_addr", 32'(cap_addr), 32'h3C4);
        chk("wr_cap_mode", 32'(cap_mode), 32'd1);
        chk("wr_mem", 32'(mem[12'h3C4]), 32'hA5);
        chk("wr_mbreq_done", 32'(mb), 32'd0);

        // Read 0x001, slave returns 0x5A with alternating svalid
        sb.push_back('{err: 1'b0, rd: 8'h5A});
        issue(1'b0, 12'h001, 8'h00);
        wait_mbits(12, "rd_addr");
        chk("rd_cap_addr", 32'(cap_addr), 32'h001);
        chk("rd_cap_mode", 32'(cap_mode), 32'd0);
        resp = 8'h5A;
        send_bits(resp, 1'b1, last_sv, mb_or, mb_and);
        chk("rd_mbreq_held", 32'(mb_and), 32'd1);
        wait_dack("rd_dack", dcyc, mb);
        chk("rd_latency", 32'(dcyc - last_sv), 32'd1);
        chk("rd_mbreq_done", 32'(mb), 32'd0);

        // Split read of 0x2AB returning 0xC3 on back-to-back svalid
        sb.push_back('{err: 1'b0, rd: 8'hC3});
        issue(1'b0, 12'h2AB, 8'h00);
        wait_mbits(12, "sp_addr");
        chk("sp_cap_addr", 32'(cap_addr), 32'h2AB);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sp_mbreq_before", 32'(mbreq), 32'd1);
        ssplit = 1'b1;
        @(posedge clk); #1;
        ssplit = 1'b0;
        chk("sp_mbreq_drop", 32'(mbreq), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        resp = 8'hC3;
        send_bits(resp, 1'b0, last_sv, mb_or, mb_and);
        chk("sp_mbreq_low", 32'(mb_or), 32'd0);
        wait_dack("sp_dack", dcyc, mb);
        chk("sp_latency", 32'(dcyc - last_sv), 32'd1);

        // Timeout: read with no svalid, drdata must stay 0xC3
        sb.push_back('{err: 1'b1, rd: 8'hC3});
        issue(1'b0, 12'h7FF, 8'h00);
        wait_mbits(12, "to_addr");
        wait_dack("to_dack", dcyc, mb);
        chk("to_latency", 32'(dcyc - (addr_last_cyc + 1)), 32'd16);

        // Grant stall: grant low 10 cycles, a stray dvalid in REQ is ignored
        mbgrant = 1'b0;
        sb.push_back('{err: 1'b0, rd: 8'hC3});
        issue(1'b1, 12'h0F0, 8'h3C);
        mv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                chk("gs_dready", 32'(dready), 32'd0);
                dvalid = 1'b1; dwen = 1'b1; daddr = 12'h0F0; dwdata = 8'hEE;
            end else begin
                dvalid = 1'b0;
            end
            mv_seen = mv_seen | mvalid;
            @(posedge clk); #1;
        end
        dvalid = 1'b0;
        chk("gs_mvalid_low", 32'(mv_seen), 32'd0);
        mbgrant = 1'b1;
        gcyc = cyc;
        wait_dack("gs_dack", dcyc, mb);
        chk("gs_latency", 32'(dcyc - gcyc), 32'd24);
        chk("gs_mem", 32'(mem[12'h0F0]), 32'h3C);

        // Reset during the 5th address bit
        issue(1'b1, 12'h555, 8'hFF);
        a0 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mvalid) begin a0 = cyc; break; end
        end
        chk("rs_addr_seen", 32'(a0 >= 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_mvalid", 32'(mvalid), 32'd0);
        chk("rs_mbreq",  32'(mbreq),  32'd0);
        chk("rs_dready", 32'(dready), 32'd1);
        chk("rs_dack",   32'(dack),   32'd0);
        repeat (4) @(posedge clk);

        // Following read of 0x3C4 returns what the first write stored
        sb.push_back('{err: 1'b0, rd: 8'hA5});
        issue(1'b0, 12'h3C4, 8'h00);
        wait_mbits(12, "rr_addr");
        chk("rr_cap_addr", 32'(cap_addr), 32'h3C4);
        resp = mem[12'h3C4];
        send_bits(resp, 1'b1, last_sv, mb_or, mb_and);
        wait_dack("rr_dack", dcyc, mb);
        chk("rr_latency", 32'(dcyc - last_sv), 32'd1);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
